// File: rtl/spio_spinn2aer_filter_pkg.sv
// SpiNNaker packet layout shared by the link, filter and mapper blocks.
// The packed struct fixes every field position inside the 72-bit packet.
package spio_spinn2aer_filter_pkg;

  localparam int PKT_W = 72;
  localparam logic [1:0] MC_TYPE = 2'b00;

  typedef struct packed {
    logic [31:0] payload;
    logic [31:0] key;
    logic [1:0]  pkt_type;
    logic [3:0]  rsvd;
    logic        pld_flag;
    logic        parity;
  } spinn_pkt_t;

  // Odd parity: without a payload, the payload word is excluded from the check.
  function automatic logic pkt_parity_ok(input spinn_pkt_t pkt);
    logic [PKT_W-1:0] raw;
    raw = pkt;
    if (pkt.pld_flag) return ^raw;
    return ^raw[39:0];
  endfunction

  function automatic logic pkt_key_match(input spinn_pkt_t pkt, input logic en,
                                         input logic [31:0] key, input logic [31:0] mask);
    if (!en) return 1'b1;
    return (pkt.pkt_type == MC_TYPE) && ((pkt.key & mask) == (key & mask));
  endfunction

endpackage

// File: rtl/spio_spinn2aer_filter_pkt_fifo.sv
// First-word-fall-through register FIFO with valid/ready on both sides.
// The head is read straight out of the register array, so it holds while the consumer stalls.
module spio_pkt_fifo #(
  parameter int WIDTH = 72,
  parameter int LOG2  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy
);

  localparam int DEPTH = 1 << LOG2;
  localparam logic [LOG2:0] DEPTH_C = (LOG2+1)'(DEPTH);
  localparam logic [LOG2:0] ONE_C   = (LOG2+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG2:0]    rd_ptr;
  logic [LOG2:0]    wr_ptr;
  logic [LOG2:0]    count;
  logic             full;
  logic             push;
  logic             pop;

  function automatic logic [LOG2:0] next_ptr(input logic [LOG2:0] p);
    return (p == DEPTH_C - ONE_C) ? '0 : p + ONE_C;
  endfunction

  // A full FIFO refuses the push even when the head pops in the same cycle.
  assign push     = in_vld & ~full;
  assign pop      = out_vld & out_rdy;
  assign in_rdy   = ~full;
  assign out_vld  = (count != '0);
  assign out_data = mem[rd_ptr[LOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[LOG2-1:0]] <= in_data;
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10: begin
          count <= count + ONE_C;
          full  <= (count == DEPTH_C - ONE_C);
        end
        2'b01: begin
          count <= count - ONE_C;
          full  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spio_spinn2aer_filter.sv
// Parity/key filter in front of the AER mapper: matching packets are queued,
// everything else is consumed and counted.
module spio_spinn2aer_filter
  import spio_spinn2aer_filter_pkg::*;
#(
  parameter int FIFO_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PKT_W-1:0] ipkt_data,
  input  logic             ipkt_vld,
  output logic             ipkt_rdy,
  output logic [PKT_W-1:0] opkt_data,
  output logic             opkt_vld,
  input  logic             opkt_rdy,
  input  logic             cfg_en,
  input  logic [31:0]      cfg_key,
  input  logic [31:0]      cfg_mask,
  input  logic             cnt_clr,
  output logic [15:0]      fwd_cnt,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      perr_cnt
);

  spinn_pkt_t pkt;
  logic       xfer;
  logic       par_ok;
  logic       match;
  logic       accept;

  assign pkt    = spinn_pkt_t'(ipkt_data);
  assign xfer   = ipkt_vld & ipkt_rdy;
  assign par_ok = pkt_parity_ok(pkt);
  assign match  = pkt_key_match(pkt, cfg_en, cfg_key, cfg_mask);
  assign accept = par_ok & match;

  // Drops still wait for ready, so a rejected packet is consumed only when a push could have happened.
  spio_pkt_fifo #(
    .WIDTH (PKT_W),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (ipkt_data),
    .in_vld   (ipkt_vld & accept),
    .in_rdy   (ipkt_rdy),
    .out_data (opkt_data),
    .out_vld  (opkt_vld),
    .out_rdy  (opkt_rdy)
  );

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt  <= '0;
      drop_cnt <= '0;
      perr_cnt <= '0;
    end else if (cnt_clr) begin
      fwd_cnt  <= '0;
      drop_cnt <= '0;
      perr_cnt <= '0;
    end else if (xfer) begin
      if (accept) fwd_cnt  <= sat_inc(fwd_cnt);
      else        drop_cnt <= sat_inc(drop_cnt);
      if (!par_ok) perr_cnt <= sat_inc(perr_cnt);
    end
  end

endmodule
